fig8_drive_sequencer: RTL and testbench
=======================================

// Module: fig8_drive_sequencer
// PURPOSE
//  Consumes the periodic single-cycle tick from the pulse generator. Drives the
//  iRobot Open Interface byte stream that makes the robot trace a figure-8:
//  circle A (+R), then circle B (-R), each held for CIRCLE_TICKS ticks.
//  Sits between the tick generator and the UART transmitter (valid/ready byte port).
// PARAMETERS
//  CIRCLE_TICKS  100      ticks spent on each circle (1..2^16-1)
//  VELOCITY      16'd200  drive velocity, mm/s, signed 16-bit
//  RADIUS        16'd250  turn radius, mm, signed 16-bit; circle B uses -RADIUS
//  LAPS          1        figure-8 repetitions; 0 = run until stop
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous, active-high reset
//  tick      in   1   one-cycle timebase pulse from the pulse generator
//  start     in   1   level/pulse; begins a run when sampled high in IDLE
//  stop      in   1   abort request; sampled every cycle outside IDLE
//  tx_ready  in   1   UART can accept a byte this cycle
//  tx_valid  out  1   tx_data holds a byte to send
//  tx_data   out  8   OI byte
//  busy      out  1   high in every state except IDLE
//  phase     out  2   0 idle/init, 1 circle A, 2 circle B, 3 halting
//  done      out  1   one-cycle pulse when the final halt packet is accepted
// BEHAVIOUR
//  Reset: tx_valid=0, tx_data=0, busy=0, phase=0, done=0, tick count=0, lap count=0,
//   abort flag=0, state IDLE. Reset mid-packet drops the packet immediately.
//  Handshake: a byte transfers on a clk edge with tx_valid&&tx_ready. tx_data stays stable
//   while tx_valid=1 && !tx_ready. tx_valid never drops before transfer. The next byte
//   is presented the cycle after transfer, so max one byte per 2 cycles. No combinational ready->valid path.
//  States: IDLE -> INIT (0x80 START, 0x83 SAFE) -> DRV_A (0x89, VEL_H, VEL_L, R_H, R_L)
//   -> WAIT_A -> DRV_B (0x89, VEL_H, VEL_L, (-R)_H, (-R)_L) -> WAIT_B -> DRV_A (next lap)
//   or HALT (0x89,00,00,00,00) -> IDLE with done=1. All 16-bit fields are big-endian.
//  WAIT_x: the counter increments on tick. Leave the state on the tick that makes count==CIRCLE_TICKS.
//   The counter clears on entry. A tick outside WAIT states is ignored.
//  Laps: the lap counter increments when leaving WAIT_B. HALT is taken when laps==LAPS (LAPS!=0).
//   The lap counter is 16-bit and wraps silently when LAPS=0.
//  stop: ignored in IDLE. In WAIT_x, go to HALT next cycle.
//   In INIT/DRV_x, set the abort flag and finish the current packet (never a truncated OI command),
//   then go to HALT. stop during HALT is ignored.
//  start: accepted only in IDLE. start&&stop in the same IDLE cycle -> run starts and stop is ignored.
//   start while busy is ignored.
//  -RADIUS is the two's complement in 16 bits. RADIUS=16'h8000 is not allowed.
//  phase: DRV_A/WAIT_A=1, DRV_B/WAIT_B=2, HALT=3, otherwise 0.
// STRUCTURE
//  Package fig8_pkg: OP_START=8'h80, OP_SAFE=8'h83, OP_DRIVE=8'h89, state encoding,
//   PKT_LEN_INIT=2, PKT_LEN_DRIVE=5.
//  Sub-module oi_packet_tx: loads up to 5 bytes plus a length, serialises them over valid/ready,
//   and raises pkt_done for one cycle after the last transfer. The FSM, tick counter and lap counter
//   stay in the top level.
// TESTING (CIRCLE_TICKS=3, VELOCITY=200, RADIUS=250 unless noted)
//  1. LAPS=1, tx_ready=1, start, tick every 20 clk -> exact stream 80 83 89 00 C8 00 FA,
//     then after 3 ticks 89 00 C8 FF 06, then after 3 ticks 89 00 00 00 00.
//     done pulses once, busy falls the same cycle.
//  2. Backpressure: tx_ready random 30% -> same byte stream; tx_data is stable while valid&&!ready.
//  3. stop asserted on the 3rd byte of the DRV_A packet -> remaining 2 bytes sent,
//     then 89 00 00 00 00 and done. No WAIT_A entered.
//  4. stop during WAIT_B after 1 tick -> HALT packet follows immediately.
//     Ticks during HALT do not change the stream.
//  5. LAPS=2 -> A,B,A,B packets, then HALT. Ticks in INIT/DRV are ignored (tick every clk case).
//  6. rst asserted mid-packet -> all outputs 0 asynchronously.
//     start after release reproduces the scenario 1 stream from 0x80.

Source files
------------

// File: rtl/fig8_pkg.sv
// Shared constants, state encoding and packet builders for the figure-8 drive sequencer.
package fig8_pkg;

  localparam logic [7:0] OP_START = 8'h80;
  localparam logic [7:0] OP_SAFE  = 8'h83;
  localparam logic [7:0] OP_DRIVE = 8'h89;

  localparam logic [2:0] PKT_LEN_INIT  = 3'd2;
  localparam logic [2:0] PKT_LEN_DRIVE = 3'd5;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_A    = 2'd1;
  localparam logic [1:0] PH_B    = 2'd2;
  localparam logic [1:0] PH_HALT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_DRV_A,
    ST_WAIT_A,
    ST_DRV_B,
    ST_WAIT_B,
    ST_HALT
  } state_t;

  // Packets are packed first-byte-first into the top of a 40-bit word.
  localparam logic [39:0] PKT_INIT = {OP_START, OP_SAFE, 24'h000000};
  localparam logic [39:0] PKT_HALT = {OP_DRIVE, 32'h00000000};

  // Drive command: opcode, velocity, radius, both 16-bit fields big-endian.
  function automatic logic [39:0] drive_pkt(input logic [15:0] vel, input logic [15:0] rad);
    return {OP_DRIVE, vel, rad};
  endfunction

endpackage

// File: rtl/oi_packet_tx.sv
// Serialises a preloaded packet of up to five bytes over a valid/ready byte port.
// After each transfer the port idles for one cycle before presenting the next byte,
// so tx_valid/tx_data are pure flops with no path from tx_ready.
module oi_packet_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [39:0] pkt,
  input  logic [2:0]  len,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        pkt_done
);

  logic [31:0] rest;
  logic [2:0]  left;
  logic        pend;

  // Load, hold the byte until accepted, then step to the next one after a gap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      pkt_done <= 1'b0;
      rest     <= 32'h0;
      left     <= 3'd0;
      pend     <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (load) begin
        tx_valid <= 1'b1;
        tx_data  <= pkt[39:32];
        rest     <= pkt[31:0];
        left     <= len;
        pend     <= 1'b0;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
        if (left == 3'd1) begin
          left     <= 3'd0;
          pkt_done <= 1'b1;
        end else begin
          left <= left - 3'd1;
          pend <= 1'b1;
        end
      end else if (pend) begin
        tx_valid <= 1'b1;
        tx_data  <= rest[31:24];
        rest     <= {rest[23:0], 8'h00};
        pend     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fig8_drive_sequencer.sv
// Figure-8 sequencer: emits the OI start/safe preamble, then alternates drive
// commands at +R and -R, dwelling CIRCLE_TICKS timebase ticks on each circle,
// and finishes with a zero-velocity drive command.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start, no packet in flight
// INIT    | sending START, SAFE
// DRV_A   | sending drive command for circle A (+RADIUS)
// WAIT_A  | counting ticks on circle A
// DRV_B   | sending drive command for circle B (-RADIUS)
// WAIT_B  | counting ticks on circle B, lap accounting on exit
// HALT    | sending stop drive command, done pulses when it completes
module fig8_drive_sequencer
  import fig8_pkg::*;
#(
  parameter int          CIRCLE_TICKS = 100,
  parameter logic [15:0] VELOCITY     = 16'd200,
  parameter logic [15:0] RADIUS       = 16'd250,
  parameter int          LAPS         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic [1:0] phase,
  output logic       done
);

  localparam logic [15:0] TICKS_TC   = 16'(CIRCLE_TICKS);
  localparam logic [15:0] LAPS_TC    = 16'(LAPS);
  localparam logic [15:0] RADIUS_NEG = 16'(16'd0 - RADIUS);
  localparam logic [39:0] PKT_A      = drive_pkt(VELOCITY, RADIUS);
  localparam logic [39:0] PKT_B      = drive_pkt(VELOCITY, RADIUS_NEG);
  localparam bit          LAPS_BOUND = (LAPS != 0);

  state_t      state;
  logic [15:0] tick_cnt;
  logic [15:0] lap_cnt;
  logic        abort;
  logic        pkt_load;
  logic [39:0] pkt_bytes;
  logic [2:0]  pkt_len;
  logic        pkt_done;

  logic [15:0] tick_next;
  logic [15:0] lap_next;
  logic        tick_tc;

  assign tick_next = tick_cnt + 16'd1;
  assign lap_next  = lap_cnt + 16'd1;
  assign tick_tc   = (tick_next == TICKS_TC);

  // Sequencing FSM; every output and packet request is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tick_cnt  <= 16'd0;
      lap_cnt   <= 16'd0;
      abort     <= 1'b0;
      pkt_load  <= 1'b0;
      pkt_bytes <= 40'h0;
      pkt_len   <= 3'd0;
      busy      <= 1'b0;
      phase     <= PH_IDLE;
      done      <= 1'b0;
    end else begin
      pkt_load <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_INIT;
            busy      <= 1'b1;
            phase     <= PH_IDLE;
            lap_cnt   <= 16'd0;
            abort     <= 1'b0;
            pkt_load  <= 1'b1;
            pkt_bytes <= PKT_INIT;
            pkt_len   <= PKT_LEN_INIT;
          end
        end
        ST_INIT: begin
          if (stop) abort <= 1'b1;
          if (pkt_done) begin
            pkt_load <= 1'b1;
            pkt_len  <= PKT_LEN_DRIVE;
            if (abort || stop) begin
              state     <= ST_HALT;
              phase     <= PH_HALT;
              pkt_bytes <= PKT_HALT;
            end else begin
              state     <= ST_DRV_A;
              phase     <= PH_A;
              pkt_bytes <= PKT_A;
            end
          end
        end
        ST_DRV_A, ST_DRV_B: begin
          if (stop) abort <= 1'b1;
          if (pkt_done) begin
            if (abort || stop) begin
              state     <= ST_HALT;
              phase     <= PH_HALT;
              pkt_load  <= 1'b1;
              pkt_bytes <= PKT_HALT;
              pkt_len   <= PKT_LEN_DRIVE;
            end else begin
              state    <= (state == ST_DRV_A) ? ST_WAIT_A : ST_WAIT_B;
              tick_cnt <= 16'd0;
            end
          end
        end
        ST_WAIT_A: begin
          if (stop) begin
            state     <= ST_HALT;
            phase     <= PH_HALT;
            pkt_load  <= 1'b1;
            pkt_bytes <= PKT_HALT;
            pkt_len   <= PKT_LEN_DRIVE;
          end else if (tick) begin
            if (tick_tc) begin
              state     <= ST_DRV_B;
              phase     <= PH_B;
              pkt_load  <= 1'b1;
              pkt_bytes <= PKT_B;
              pkt_len   <= PKT_LEN_DRIVE;
            end else begin
              tick_cnt <= tick_next;
            end
          end
        end
        ST_WAIT_B: begin
          if (stop) begin
            state     <= ST_HALT;
            phase     <= PH_HALT;
            pkt_load  <= 1'b1;
            pkt_bytes <= PKT_HALT;
            pkt_len   <= PKT_LEN_DRIVE;
          end else if (tick) begin
            if (tick_tc) begin
              lap_cnt  <= lap_next;
              pkt_load <= 1'b1;
              pkt_len  <= PKT_LEN_DRIVE;
              if (LAPS_BOUND && (lap_next == LAPS_TC)) begin
                state     <= ST_HALT;
                phase     <= PH_HALT;
                pkt_bytes <= PKT_HALT;
              end else begin
                state     <= ST_DRV_A;
                phase     <= PH_A;
                pkt_bytes <= PKT_A;
              end
            end else begin
              tick_cnt <= tick_next;
            end
          end
        end
        ST_HALT: begin
          if (pkt_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            phase <= PH_IDLE;
            abort <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          phase <= PH_IDLE;
        end
      endcase
    end
  end

  oi_packet_tx u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (pkt_load),
    .pkt      (pkt_bytes),
    .len      (pkt_len),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .pkt_done (pkt_done)
  );

endmodule

// File: tb/tb_fig8_drive_sequencer.sv
// Directed bench for fig8_drive_sequencer: one instance with LAPS=1, one with LAPS=2.
module tb_fig8_drive_sequencer;

  typedef logic [7:0] byte_q [$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic tx_ready = 1'b0;
  logic sel = 1'b0;

  logic       v1, v2, busy1, busy2, done1, done2;
  logic [7:0] d1, d2;
  logic [1:0] ph1, ph2;
  logic       start_a, start_b;

  logic       o_valid, o_busy, o_done;
  logic [7:0] o_data;
  logic [1:0] o_phase;

  assign start_a = start && !sel;
  assign start_b = start && sel;
  assign o_valid = sel ? v2 : v1;
  assign o_data  = sel ? d2 : d1;
  assign o_busy  = sel ? busy2 : busy1;
  assign o_done  = sel ? done2 : done1;
  assign o_phase = sel ? ph2 : ph1;

  fig8_drive_sequencer #(.CIRCLE_TICKS(3), .VELOCITY(16'd200), .RADIUS(16'd250), .LAPS(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start_a), .stop(stop), .tx_ready(tx_ready),
    .tx_valid(v1), .tx_data(d1), .busy(busy1), .phase(ph1), .done(done1)
  );

  fig8_drive_sequencer #(.CIRCLE_TICKS(3), .VELOCITY(16'd200), .RADIUS(16'd250), .LAPS(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .start(start_b), .stop(stop), .tx_ready(tx_ready),
    .tx_valid(v2), .tx_data(d2), .busy(busy2), .phase(ph2), .done(done2)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tick_mode = 0;
  int tick_div = 0;
  bit rdy_rand = 1'b0;

  byte_q cap;
  int    cap_cyc [$];
  int    done_cnt = 0;
  int    done_busy_err = 0;
  int    stab_err = 0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(posedge clk) cyc++;

  // Free-running stimulus: random ready and periodic/continuous ticks.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) tx_ready = ($urandom_range(0, 99) < 30);
    if (tick_mode == 2) tick = 1'b1;
    else if (tick_mode == 1) begin
      tick_div++;
      tick = (tick_div % 20 == 0);
    end
  end

  // Byte capture and handshake observation, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && tx_ready) begin
        cap.push_back(o_data);
        cap_cyc.push_back(cyc);
      end
      if (prev_v && !prev_r && (!o_valid || o_data !== prev_d)) stab_err++;
      prev_v = o_valid;
      prev_r = tx_ready;
      prev_d = o_data;
      if (o_done) begin
        done_cnt++;
        if (o_busy) done_busy_err++;
      end
    end
  end

  task automatic clk1;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs;
    cap.delete();
    cap_cyc.delete();
    done_cnt = 0;
    done_busy_err = 0;
    stab_err = 0;
    prev_v = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    clk1();
    start = 1'b0;
  endtask

  task automatic pulse_tick;
    tick = 1'b1;
    clk1();
    tick = 1'b0;
  endtask

  task automatic wait_cap(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (cap.size() >= n) ok = 1'b1;
      else clk1();
    end
    if (cap.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done_cnt > 0) ok = 1'b1;
      else clk1();
    end
    if (done_cnt > 0) ok = 1'b1;
    repeat (4) clk1();
  endtask

  function automatic int first_diff(input byte_q exp);
    int n;
    n = (cap.size() < exp.size()) ? cap.size() : exp.size();
    for (int i = 0; i < n; i++) if (cap[i] !== exp[i]) return i;
    if (cap.size() != exp.size()) return n;
    return -1;
  endfunction

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if ({o_valid, o_data, o_busy, o_phase, o_done} !== 13'd0) begin
      fails++;
      $display("FAIL reset_held: got v=%b d=%h busy=%b ph=%0d done=%b, want all 0",
               o_valid, o_data, o_busy, o_phase, o_done);
    end
    rst = 1'b0;
    clk1();
    clk1();
    tests++;
    if ({v1, d1, busy1, ph1, done1, v2, d2, busy2, ph2, done2} !== 26'd0) begin
      fails++;
      $display("FAIL reset_released: outputs not idle (d1=%h d2=%h busy=%b%b)", d1, d2, busy1, busy2);
    end
  endtask

  task automatic test_basic;
    byte_q exp;
    bit ok;
    int d;
    exp = {8'h80, 8'h83, 8'h89, 8'h00, 8'hC8, 8'h00, 8'hFA,
           8'h89, 8'h00, 8'hC8, 8'hFF, 8'h06,
           8'h89, 8'h00, 8'h00, 8'h00, 8'h00};
    sel = 1'b0; rdy_rand = 1'b0; tx_ready = 1'b1; tick_mode = 0; tick = 1'b0;
    clear_obs();
    pulse_start();
    tests++;
    if (o_busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy_start: got %b, want 1", o_busy);
    end
    wait_cap(7, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_pkt_a_timeout: got %0d bytes, want 7", cap.size()); end
    repeat (5) clk1();
    tests++;
    if (o_phase !== 2'd1) begin fails++; $display("FAIL basic_phase_wait_a: got %0d, want 1", o_phase); end
    tests++;
    if (cap_cyc.size() < 2 || cap_cyc[1] - cap_cyc[0] !== 2) begin
      fails++;
      $display("FAIL basic_byte_spacing: got %0d cycles, want 2",
               (cap_cyc.size() < 2) ? -1 : cap_cyc[1] - cap_cyc[0]);
    end
    pulse_tick(); repeat (19) clk1();
    pulse_tick(); repeat (19) clk1();
    tests++;
    if (cap.size() !== 7) begin fails++; $display("FAIL basic_wait_a_2ticks: got %0d bytes, want 7", cap.size()); end
    pulse_tick();
    wait_cap(12, 40, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_pkt_b_timeout: got %0d bytes, want 12", cap.size()); end
    repeat (5) clk1();
    tests++;
    if (o_phase !== 2'd2) begin fails++; $display("FAIL basic_phase_wait_b: got %0d, want 2", o_phase); end
    pulse_tick(); repeat (19) clk1();
    pulse_tick(); repeat (19) clk1();
    tests++;
    if (cap.size() !== 12) begin fails++; $display("FAIL basic_wait_b_2ticks: got %0d bytes, want 12", cap.size()); end
    pulse_tick();
    wait_done(60, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_done_timeout: got done_cnt %0d, want 1", done_cnt); end
    d = first_diff(exp);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL basic_stream: first difference at byte %0d, got %0d bytes, want %0d", d, cap.size(), exp.size());
    end
    tests++;
    if (done_cnt !== 1 || done_busy_err !== 0) begin
      fails++;
      $display("FAIL basic_done_pulse: got %0d pulses (%0d with busy high), want 1 (0)", done_cnt, done_busy_err);
    end
    tests++;
    if (o_busy !== 1'b0 || o_phase !== 2'd0) begin
      fails++;
      $display("FAIL basic_idle_after: got busy=%b phase=%0d, want 0 0", o_busy, o_phase);
    end
  endtask

  task automatic test_backpressure;
    byte_q exp;
    bit ok;
    int d;
    exp = {8'h80, 8'h83, 8'h89, 8'h00, 8'hC8, 8'h00, 8'hFA,
           8'h89, 8'h00, 8'hC8, 8'hFF, 8'h06,
           8'h89, 8'h00, 8'h00, 8'h00, 8'h00};
    sel = 1'b0; tick_mode = 1; rdy_rand = 1'b1;
    clear_obs();
    pulse_start();
    wait_done(3000, ok);
    rdy_rand = 1'b0; tx_ready = 1'b1;
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_done_timeout: got %0d bytes, want done", cap.size()); end
    d = first_diff(exp);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL bp_stream: first difference at byte %0d, got %0d bytes, want %0d", d, cap.size(), exp.size());
    end
    tests++;
    if (stab_err !== 0) begin fails++; $display("FAIL bp_data_stable: got %0d unstable cycles, want 0", stab_err); end
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL bp_done_count: got %0d, want 1", done_cnt); end
  endtask

  task automatic test_stop_drv;
    byte_q exp;
    bit ok;
    bit hit;
    int d;
    exp = {8'h80, 8'h83, 8'h89, 8'h00, 8'hC8, 8'h00, 8'hFA,
           8'h89, 8'h00, 8'h00, 8'h00, 8'h00};
    sel = 1'b0; tick_mode = 1; tx_ready = 1'b1;
    clear_obs();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (cap.size() == 4 && o_valid) hit = 1'b1;
      else clk1();
    end
    tests++;
    if (!hit || o_data !== 8'hC8) begin
      fails++;
      $display("FAIL stop_third_byte: got data %h (reached=%b), want c8", o_data, hit);
    end
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    wait_done(300, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stop_done_timeout: got %0d bytes, want done", cap.size()); end
    d = first_diff(exp);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL stop_stream: first difference at byte %0d, got %0d bytes, want %0d", d, cap.size(), exp.size());
    end
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL stop_done_count: got %0d, want 1", done_cnt); end
  endtask

  task automatic test_stop_wait_b;
    byte_q exp;
    bit ok;
    int d;
    exp = {8'h80, 8'h83, 8'h89, 8'h00, 8'hC8, 8'h00, 8'hFA,
           8'h89, 8'h00, 8'hC8, 8'hFF, 8'h06,
           8'h89, 8'h00, 8'h00, 8'h00, 8'h00};
    sel = 1'b0; tick_mode = 0; tick = 1'b0; tx_ready = 1'b1;
    clear_obs();
    pulse_start();
    wait_cap(7, 200, ok);
    repeat (5) clk1();
    repeat (3) begin pulse_tick(); repeat (19) clk1(); end
    tests++;
    if (cap.size() !== 12) begin fails++; $display("FAIL wb_reach_wait_b: got %0d bytes, want 12", cap.size()); end
    pulse_tick();
    repeat (5) clk1();
    stop = 1'b1;
    tick_mode = 2;
    clk1();
    stop = 1'b0;
    tests++;
    if (o_phase !== 2'd3) begin fails++; $display("FAIL wb_phase_halt: got %0d, want 3", o_phase); end
    wait_cap(13, 4, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL wb_halt_immediate: got %0d bytes, want 13", cap.size()); end
    wait_done(100, ok);
    tick_mode = 0;
    tick = 1'b0;
    d = first_diff(exp);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL wb_stream: first difference at byte %0d, got %0d bytes, want %0d", d, cap.size(), exp.size());
    end
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL wb_done_count: got %0d, want 1", done_cnt); end
  endtask

  task automatic test_two_laps;
    byte_q exp;
    bit ok;
    int d;
    exp = {8'h80, 8'h83,
           8'h89, 8'h00, 8'hC8, 8'h00, 8'hFA, 8'h89, 8'h00, 8'hC8, 8'hFF, 8'h06,
           8'h89, 8'h00, 8'hC8, 8'h00, 8'hFA, 8'h89, 8'h00, 8'hC8, 8'hFF, 8'h06,
           8'h89, 8'h00, 8'h00, 8'h00, 8'h00};
    sel = 1'b1; tick_mode = 2; tx_ready = 1'b1;
    clear_obs();
    pulse_start();
    wait_done(500, ok);
    tick_mode = 0;
    tick = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL laps2_done_timeout: got %0d bytes, want done", cap.size()); end
    d = first_diff(exp);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL laps2_stream: first difference at byte %0d, got %0d bytes, want %0d", d, cap.size(), exp.size());
    end
    tests++;
    if (cap_cyc.size() < 8 || cap_cyc[7] - cap_cyc[6] !== 6) begin
      fails++;
      $display("FAIL laps2_wait_a_len: got %0d cycles, want 6", (cap_cyc.size() < 8) ? -1 : cap_cyc[7] - cap_cyc[6]);
    end
    tests++;
    if (cap_cyc.size() < 13 || cap_cyc[12] - cap_cyc[11] !== 6) begin
      fails++;
      $display("FAIL laps2_wait_b_len: got %0d cycles, want 6", (cap_cyc.size() < 13) ? -1 : cap_cyc[12] - cap_cyc[11]);
    end
    tests++;
    if (done_cnt !== 1 || done_busy_err !== 0) begin
      fails++;
      $display("FAIL laps2_done_pulse: got %0d pulses (%0d with busy high), want 1 (0)", done_cnt, done_busy_err);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    byte_q exp;
    bit ok;
    int d;
    exp = {8'h80, 8'h83, 8'h89, 8'h00, 8'hC8, 8'h00, 8'hFA,
           8'h89, 8'h00, 8'hC8, 8'hFF, 8'h06,
           8'h89, 8'h00, 8'h00, 8'h00, 8'h00};
    sel = 1'b0; tick_mode = 1; tx_ready = 1'b1;
    clear_obs();
    pulse_start();
    wait_cap(3, 100, ok);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({o_valid, o_data, o_busy, o_phase, o_done} !== 13'd0) begin
      fails++;
      $display("FAIL rst_mid_async: got v=%b d=%h busy=%b ph=%0d done=%b, want all 0",
               o_valid, o_data, o_busy, o_phase, o_done);
    end
    clk1();
    clk1();
    rst = 1'b0;
    clk1();
    clear_obs();
    start = 1'b1;
    stop = 1'b1;
    clk1();
    start = 1'b0;
    stop = 1'b0;
    wait_done(2000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_restart_timeout: got %0d bytes, want done", cap.size()); end
    d = first_diff(exp);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL rst_restart_stream: first difference at byte %0d, got %0d bytes, want %0d", d, cap.size(), exp.size());
    end
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL rst_restart_done: got %0d, want 1", done_cnt); end
    tick_mode = 0;
    tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stop_drv();
    test_stop_wait_b();
    test_two_laps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
